// File: rtl/insn_encoder_pkg.sv
// rtl/insn_encoder_pkg.sv - shared class/ALU/opcode constants and RV32I field packing
package insn_encoder_pkg;

  typedef enum logic [3:0] {
    R_TYPE   = 4'd0,
    IMM      = 4'd1,
    LOADS    = 4'd2,
    STORES   = 4'd3,
    BRANCHES = 4'd4,
    JAL      = 4'd5,
    JALR     = 4'd6,
    LUI      = 4'd7,
    AUIPC    = 4'd8
  } insn_class_e;

  typedef enum logic [3:0] {
    ADD   = 4'd0,
    SUB   = 4'd1,
    SLL   = 4'd2,
    SLT   = 4'd3,
    SLTU  = 4'd4,
    XOR   = 4'd5,
    SRL   = 4'd6,
    SRA   = 4'd7,
    OR    = 4'd8,
    AND   = 4'd9,
    PCADD = 4'd10
  } alu_sel_e;

  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

  function automatic logic [2:0] alu_funct3(input logic [3:0] alu);
    logic [2:0] f3;
    case (alu)
      SLL:      f3 = 3'b001;
      SLT:      f3 = 3'b010;
      SLTU:     f3 = 3'b011;
      XOR:      f3 = 3'b100;
      SRL, SRA: f3 = 3'b101;
      OR:       f3 = 3'b110;
      AND:      f3 = 3'b111;
      default:  f3 = 3'b000;
    endcase
    return f3;
  endfunction

  // Assumes the request already passed the legality check.
  function automatic logic [31:0] pack_insn(
    input logic [3:0]  cls,
    input logic [3:0]  alu,
    input logic [2:0]  f3,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    logic [31:0] w;
    logic [2:0]  af3;
    logic        alt;
    af3 = alu_funct3(alu);
    alt = (alu == SUB) || (alu == SRA);
    w   = NOP_INSN;
    case (cls)
      R_TYPE:   w = {1'b0, alt, 5'b0, rs2, rs1, af3, rd, OPC_OP};
      IMM: begin
        if (alu == SLL || alu == SRL || alu == SRA)
          w = {1'b0, alt, 5'b0, imm[4:0], rs1, af3, rd, OPC_OP_IMM};
        else
          w = {imm[11:0], rs1, af3, rd, OPC_OP_IMM};
      end
      LOADS:    w = {imm[11:0], rs1, f3, rd, OPC_LOAD};
      STORES:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
      BRANCHES: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
      JAL:      w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      JALR:     w = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
      LUI:      w = {imm[31:12], rd, OPC_LUI};
      AUIPC:    w = {imm[31:12], rd, OPC_AUIPC};
      default:  w = NOP_INSN;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/insn_field_check.sv
// rtl/insn_field_check.sv - combinational legality/range check of an encode request
module insn_field_check
  import insn_encoder_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [3:0]        class_i,
  input  logic [3:0]        alusel_i,
  input  logic [2:0]        funct3_i,
  input  logic [DWIDTH-1:0] imm_i,
  output logic              illegal_o
);

  // True when v is representable as a two's-complement value of 'bits' bits.
  function automatic logic fits_signed(input logic [DWIDTH-1:0] v, input int unsigned bits);
    logic [DWIDTH-1:0] hi;
    hi = $signed(v) >>> (bits - 1);
    return (hi == '0) || (hi == '1);
  endfunction

  logic fits12;
  logic shamt_ok;

  assign fits12   = fits_signed(imm_i, 12);
  assign shamt_ok = (imm_i >> 5) == '0;

  always_comb begin
    illegal_o = 1'b0;
    case (class_i)
      R_TYPE: illegal_o = alusel_i > AND;
      IMM: begin
        case (alusel_i)
          ADD, XOR, OR, AND, SLT, SLTU: illegal_o = !fits12;
          SLL, SRL, SRA:                illegal_o = !shamt_ok;
          default:                      illegal_o = 1'b1;
        endcase
      end
      LOADS:    illegal_o = !fits12 || !(funct3_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      STORES:   illegal_o = !fits12 || (funct3_i > 3'd2);
      BRANCHES: illegal_o = !fits_signed(imm_i, 13) || imm_i[0] || (funct3_i inside {3'd2, 3'd3});
      JAL:      illegal_o = !fits_signed(imm_i, 21) || imm_i[0];
      JALR:     illegal_o = !fits12;
      LUI, AUIPC: illegal_o = imm_i[11:0] != 12'd0;
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/insn_encoder.sv
// rtl/insn_encoder.sv - two-stage RV32I instruction encoder with valid/ready handshakes
module insn_encoder
  import insn_encoder_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [3:0]        class_i,
  input  logic [3:0]        alusel_i,
  input  logic [2:0]        funct3_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [DWIDTH-1:0] imm_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DWIDTH-1:0] insn_o,
  output logic              err_o,
  output logic [15:0]       enc_cnt_o,
  output logic [15:0]       err_cnt_o
);

  logic              s1_valid_q, s1_valid_d;
  logic [3:0]        s1_class_q, s1_class_d;
  logic [3:0]        s1_alu_q,   s1_alu_d;
  logic [2:0]        s1_f3_q,    s1_f3_d;
  logic [4:0]        s1_rd_q,    s1_rd_d;
  logic [4:0]        s1_rs1_q,   s1_rs1_d;
  logic [4:0]        s1_rs2_q,   s1_rs2_d;
  logic [DWIDTH-1:0] s1_imm_q,   s1_imm_d;

  logic              s2_valid_q, s2_valid_d;
  logic [DWIDTH-1:0] s2_insn_q,  s2_insn_d;
  logic              s2_err_q,   s2_err_d;
  logic [15:0]       enc_cnt_q,  enc_cnt_d;
  logic [15:0]       err_cnt_q,  err_cnt_d;

  logic        s2_free;
  logic        out_xfer;
  logic        s1_illegal;
  logic [31:0] s1_word;

  insn_field_check #(.DWIDTH(DWIDTH)) u_field_check (
    .class_i   (s1_class_q),
    .alusel_i  (s1_alu_q),
    .funct3_i  (s1_f3_q),
    .imm_i     (s1_imm_q),
    .illegal_o (s1_illegal)
  );

  assign s1_word = s1_illegal ? NOP_INSN
                 : pack_insn(s1_class_q, s1_alu_q, s1_f3_q, s1_rd_q, s1_rs1_q, s1_rs2_q, s1_imm_q[31:0]);

  // Depends only on registered state and ready_i, never on valid_i.
  assign s2_free  = !s2_valid_q || ready_i;
  assign ready_o  = !s1_valid_q || s2_free;
  assign out_xfer = s2_valid_q && ready_i;

  assign valid_o   = s2_valid_q;
  assign insn_o    = s2_insn_q;
  assign err_o     = s2_err_q;
  assign enc_cnt_o = enc_cnt_q;
  assign err_cnt_o = err_cnt_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_class_d = s1_class_q;
    s1_alu_d   = s1_alu_q;
    s1_f3_d    = s1_f3_q;
    s1_rd_d    = s1_rd_q;
    s1_rs1_d   = s1_rs1_q;
    s1_rs2_d   = s1_rs2_q;
    s1_imm_d   = s1_imm_q;
    s2_valid_d = s2_valid_q;
    s2_insn_d  = s2_insn_q;
    s2_err_d   = s2_err_q;
    enc_cnt_d  = enc_cnt_q;
    err_cnt_d  = err_cnt_q;

    if (ready_o) begin
      s1_valid_d = valid_i;
      if (valid_i) begin
        s1_class_d = class_i;
        s1_alu_d   = alusel_i;
        s1_f3_d    = funct3_i;
        s1_rd_d    = rd_i;
        s1_rs1_d   = rs1_i;
        s1_rs2_d   = rs2_i;
        s1_imm_d   = imm_i;
      end
    end

    if (s2_free) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_insn_d = DWIDTH'(s1_word);
        s2_err_d  = s1_illegal;
      end
    end

    if (out_xfer) begin
      if (s2_err_q && err_cnt_q != 16'hFFFF)
        err_cnt_d = err_cnt_q + 16'd1;
      if (!s2_err_q && enc_cnt_q != 16'hFFFF)
        enc_cnt_d = enc_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_class_q <= '0;
      s1_alu_q   <= '0;
      s1_f3_q    <= '0;
      s1_rd_q    <= '0;
      s1_rs1_q   <= '0;
      s1_rs2_q   <= '0;
      s1_imm_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_insn_q  <= '0;
      s2_err_q   <= 1'b0;
      enc_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_class_q <= s1_class_d;
      s1_alu_q   <= s1_alu_d;
      s1_f3_q    <= s1_f3_d;
      s1_rd_q    <= s1_rd_d;
      s1_rs1_q   <= s1_rs1_d;
      s1_rs2_q   <= s1_rs2_d;
      s1_imm_q   <= s1_imm_d;
      s2_valid_q <= s2_valid_d;
      s2_insn_q  <= s2_insn_d;
      s2_err_q   <= s2_err_d;
      enc_cnt_q  <= enc_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_insn_encoder.sv
// tb/tb_insn_encoder.sv - directed and round-trip bench for insn_encoder
module tb_insn_encoder;
  import insn_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b0;
  logic        ready_o, valid_o, err_o;
  logic [3:0]  class_i = '0, alusel_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [4:0]  rd_i = '0, rs1_i = '0, rs2_i = '0;
  logic [31:0] imm_i = '0;
  logic [31:0] insn_o;
  logic [15:0] enc_cnt_o, err_cnt_o;

  int n_vec = 0;
  int n_bad = 0;
  int exp_enc = 0;
  int exp_err = 0;

  insn_encoder #(.DWIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready_o),
    .class_i(class_i), .alusel_i(alusel_i), .funct3_i(funct3_i),
    .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
    .valid_o(valid_o), .ready_i(ready_i), .insn_o(insn_o), .err_o(err_o),
    .enc_cnt_o(enc_cnt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  c;
    logic [3:0]  a;
    logic [2:0]  f;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] w;
    logic        e;
  } vec_t;

  task automatic set_req(input logic [3:0] c, input logic [3:0] a, input logic [2:0] f,
                         input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [31:0] im);
    class_i = c; alusel_i = a; funct3_i = f;
    rd_i = d; rs1_i = s1; rs2_i = s2; imm_i = im;
  endtask

  // Single request through an empty pipeline; lat = -1 if valid_o never rose.
  task automatic run_req(input logic [3:0] c, input logic [3:0] a, input logic [2:0] f,
                         input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [31:0] im, output logic [31:0] w, output logic e,
                         output int lat);
    @(negedge clk);
    set_req(c, a, f, d, s1, s2, im);
    valid_i = 1'b1;
    ready_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    w = insn_o;
    e = err_o;
    if (!valid_o) lat = -1;
    @(negedge clk);
  endtask

  function automatic void decode(input logic [31:0] w, output logic [3:0] c, output logic [3:0] a);
    c = 4'hF;
    a = 4'hF;
    case (w[6:0])
      7'b0110011, 7'b0010011: begin
        c = (w[6:0] == 7'b0110011) ? R_TYPE : IMM;
        case (w[14:12])
          3'd0: a = (w[5] && w[30]) ? SUB : ADD;
          3'd1: a = SLL;
          3'd2: a = SLT;
          3'd3: a = SLTU;
          3'd4: a = XOR;
          3'd5: a = w[30] ? SRA : SRL;
          3'd6: a = OR;
          default: a = AND;
        endcase
      end
      7'b0000011: begin c = LOADS;    a = ADD;   end
      7'b0100011: begin c = STORES;   a = ADD;   end
      7'b1100011: begin c = BRANCHES; a = SUB;   end
      7'b1101111: begin c = JAL;      a = PCADD; end
      7'b1100111: begin c = JALR;     a = ADD;   end
      7'b0110111: begin c = LUI;      a = ADD;   end
      7'b0010111: begin c = AUIPC;    a = PCADD; end
      default: ;
    endcase
  endfunction

  task automatic test_reset();
    #2 reset_n = 1'b0;
    @(negedge clk);
    n_vec++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    n_vec++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
    n_vec++; if (insn_o !== 32'h0) begin n_bad++; $display("FAIL reset_insn: got %h expected 00000000", insn_o); end
    n_vec++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", err_o); end
    n_vec++; if (enc_cnt_o !== 16'd0 || err_cnt_o !== 16'd0) begin
      n_bad++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", enc_cnt_o, err_cnt_o); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_vec++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready: got %b expected 1", ready_o); end
  endtask

  task automatic test_imm_add();
    logic [31:0] w; logic e; int lat;
    run_req(IMM, ADD, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, w, e, lat);
    exp_enc++;
    n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL imm_add_latency: got %0d expected 2", lat); end
    n_vec++; if (w !== 32'h00500093) begin n_bad++; $display("FAIL imm_add_insn: got %h expected 00500093", w); end
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL imm_add_err: got %b expected 0", e); end
    n_vec++; if (enc_cnt_o !== 16'(exp_enc)) begin n_bad++; $display("FAIL imm_add_enc_cnt: got %0d expected %0d", enc_cnt_o, exp_enc); end
  endtask

  task automatic test_rtype_sub();
    logic [31:0] w; logic e; int lat;
    run_req(R_TYPE, SUB, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, w, e, lat);
    exp_enc++;
    n_vec++; if (w !== 32'h402081B3) begin n_bad++; $display("FAIL rtype_sub_insn: got %h expected 402081b3", w); end
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL rtype_sub_err: got %b expected 0", e); end
  endtask

  task automatic test_branch_odd();
    logic [31:0] w; logic e; int lat;
    run_req(BRANCHES, SUB, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3, w, e, lat);
    exp_err++;
    n_vec++; if (w !== 32'h00000013) begin n_bad++; $display("FAIL branch_odd_insn: got %h expected 00000013", w); end
    n_vec++; if (e !== 1'b1) begin n_bad++; $display("FAIL branch_odd_err: got %b expected 1", e); end
    n_vec++; if (err_cnt_o !== 16'd1) begin n_bad++; $display("FAIL branch_odd_err_cnt: got %0d expected 1", err_cnt_o); end
  endtask

  task automatic test_boundaries();
    vec_t tbl[17];
    logic [31:0] w; logic e; int lat;
    tbl = '{
      '{IMM,      ADD,   3'd0, 5'd1, 5'd0, 5'd0, 32'd2047,     32'h7FF00093, 1'b0},
      '{IMM,      ADD,   3'd0, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h00000013, 1'b1},
      '{IMM,      ADD,   3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 32'h80000093, 1'b0},
      '{IMM,      SRA,   3'd0, 5'd1, 5'd2, 5'd0, 32'd31,       32'h41F15093, 1'b0},
      '{IMM,      SLL,   3'd0, 5'd1, 5'd0, 5'd0, 32'd32,       32'h00000013, 1'b1},
      '{IMM,      SUB,   3'd0, 5'd1, 5'd0, 5'd0, 32'd1,        32'h00000013, 1'b1},
      '{R_TYPE,   PCADD, 3'd0, 5'd1, 5'd1, 5'd2, 32'd0,        32'h00000013, 1'b1},
      '{LUI,      ADD,   3'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0},
      '{LUI,      ADD,   3'd0, 5'd5, 5'd0, 5'd0, 32'h12345001, 32'h00000013, 1'b1},
      '{JAL,      PCADD, 3'd0, 5'd1, 5'd0, 5'd0, 32'h000FFFFE, 32'h7FFFF0EF, 1'b0},
      '{JAL,      PCADD, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00100000, 32'h00000013, 1'b1},
      '{BRANCHES, SUB,   3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFF000, 32'h80208063, 1'b0},
      '{BRANCHES, SUB,   3'd2, 5'd0, 5'd1, 5'd2, 32'd4,        32'h00000013, 1'b1},
      '{LOADS,    ADD,   3'd3, 5'd1, 5'd1, 5'd0, 32'd0,        32'h00000013, 1'b1},
      '{STORES,   ADD,   3'd2, 5'd0, 5'd2, 5'd3, 32'hFFFFFFFC, 32'hFE312E23, 1'b0},
      '{4'd9,     ADD,   3'd0, 5'd1, 5'd0, 5'd0, 32'd0,        32'h00000013, 1'b1},
      '{JALR,     ADD,   3'd0, 5'd1, 5'd5, 5'd0, 32'hFFFFFFFF, 32'hFFF280E7, 1'b0}
    };
    for (int i = 0; i < 17; i++) begin
      run_req(tbl[i].c, tbl[i].a, tbl[i].f, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, w, e, lat);
      if (tbl[i].e) exp_err++; else exp_enc++;
      n_vec++; if (w !== tbl[i].w || e !== tbl[i].e) begin
        n_bad++; $display("FAIL boundary_%0d: got %h/%b expected %h/%b", i, w, e, tbl[i].w, tbl[i].e); end
    end
    n_vec++; if (enc_cnt_o !== 16'(exp_enc) || err_cnt_o !== 16'(exp_err)) begin
      n_bad++; $display("FAIL boundary_counters: got %0d/%0d expected %0d/%0d", enc_cnt_o, err_cnt_o, exp_enc, exp_err); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w[4];
    logic [31:0] held_w;
    logic        held;
    logic        saw_full;
    int          sent, got;
    exp_w = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    exp_enc = 0; exp_err = 0;
    sent = 0; got = 0; held = 1'b0; held_w = '0; saw_full = 1'b0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      ready_i = (c >= 5);
      if (sent < 4) begin
        set_req(IMM, ADD, 3'd0, 5'(sent + 1), 5'd0, 5'd0, 32'(sent + 1));
        valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
      #1;
      if (c == 2) begin
        saw_full = 1'b1;
        n_vec++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_full: got %b expected 0", ready_o); end
      end
      if (held) begin
        n_vec++; if (valid_o !== 1'b1 || insn_o !== held_w) begin
          n_bad++; $display("FAIL b2b_hold: got %b/%h expected 1/%h", valid_o, insn_o, held_w); end
      end
      held   = valid_o && !ready_i;
      held_w = insn_o;
      if (valid_i && ready_o) sent++;
      if (valid_o && ready_i) begin
        n_vec++; if (insn_o !== exp_w[got]) begin
          n_bad++; $display("FAIL b2b_word_%0d: got %h expected %h", got, insn_o, exp_w[got]); end
        got++;
      end
    end
    @(negedge clk);
    valid_i = 1'b0;
    exp_enc = 4;
    n_vec++; if (!saw_full || got !== 4) begin n_bad++; $display("FAIL b2b_count: got %0d expected 4", got); end
    n_vec++; if (enc_cnt_o !== 16'd4) begin n_bad++; $display("FAIL b2b_enc_cnt: got %0d expected 4", enc_cnt_o); end
  endtask

  task automatic test_reset_midflight();
    logic seen;
    @(negedge clk);
    ready_i = 1'b0;
    set_req(IMM, ADD, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    valid_i = 1'b1;
    @(negedge clk);
    set_req(IMM, ADD, 3'd0, 5'd2, 5'd0, 5'd0, 32'd2);
    @(negedge clk);
    valid_i = 1'b0;
    n_vec++; if (valid_o !== 1'b1 || ready_o !== 1'b0) begin
      n_bad++; $display("FAIL midflight_full: got valid %b ready %b expected 1 0", valid_o, ready_o); end
    n_vec++; if (enc_cnt_o !== 16'(exp_enc)) begin n_bad++; $display("FAIL midflight_pre_cnt: got %0d expected %0d", enc_cnt_o, exp_enc); end
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL midflight_valid: got %b expected 0", valid_o); end
    n_vec++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL midflight_ready: got %b expected 1", ready_o); end
    n_vec++; if (enc_cnt_o !== 16'd0 || err_cnt_o !== 16'd0) begin
      n_bad++; $display("FAIL midflight_counters: got %0d/%0d expected 0/0", enc_cnt_o, err_cnt_o); end
    n_vec++; if (insn_o !== 32'h0 || err_o !== 1'b0) begin
      n_bad++; $display("FAIL midflight_insn: got %h/%b expected 00000000/0", insn_o, err_o); end
    @(negedge clk);
    reset_n = 1'b1;
    ready_i = 1'b1;
    exp_enc = 0; exp_err = 0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (valid_o) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midflight_stale: got valid_o=1 expected 0"); end
    n_vec++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL midflight_post_ready: got %b expected 1", ready_o); end
  endtask

  task automatic gen_legal(output logic [3:0] c, output logic [3:0] a, output logic [2:0] f,
                           output logic [31:0] im);
    logic [3:0] imm_alus[9];
    logic [2:0] ld_f3[5];
    logic [2:0] br_f3[6];
    logic [31:0] r;
    imm_alus = '{ADD, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU};
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    c = 4'($urandom_range(0, 8));
    f = 3'd0;
    a = ADD;
    im = $urandom_range(0, 4095) - 32'd2048;
    case (c)
      R_TYPE: a = 4'($urandom_range(0, 9));
      IMM: begin
        a = imm_alus[$urandom_range(0, 8)];
        if (a == SLL || a == SRL || a == SRA) im = $urandom_range(0, 31);
      end
      LOADS:  f = ld_f3[$urandom_range(0, 4)];
      STORES: f = 3'($urandom_range(0, 2));
      BRANCHES: begin
        a = SUB;
        f = br_f3[$urandom_range(0, 5)];
        im = ($urandom_range(0, 4095) - 32'd2048) * 32'd2;
      end
      JAL: begin
        a = PCADD;
        im = ($urandom_range(0, 1048575) - 32'd524288) * 32'd2;
      end
      LUI, AUIPC: begin
        r = $urandom();
        im = {r[31:12], 12'h000};
        a = (c == AUIPC) ? PCADD : ADD;
      end
      default: ;
    endcase
  endtask

  task automatic test_random_roundtrip();
    localparam int N = 10000;
    logic [7:0] exp_q[$];
    logic [3:0] c, a, dc, da;
    logic [2:0] f;
    logic [31:0] im;
    logic [7:0] e;
    int sent, got;
    logic last_in;
    sent = 0; got = 0; last_in = 1'b0;
    for (int cyc = 0; cyc < 40000 && got < N; cyc++) begin
      @(negedge clk);
      ready_i = ($urandom_range(0, 3) != 0);
      if (last_in) valid_i = 1'b0;
      if (!valid_i && sent < N) begin
        gen_legal(c, a, f, im);
        set_req(c, a, f, 5'($urandom()), 5'($urandom()), 5'($urandom()), im);
        valid_i = 1'b1;
      end
      #1;
      last_in = valid_i && ready_o;
      if (last_in) begin
        exp_q.push_back({class_i, alusel_i});
        sent++;
      end
      if (valid_o && ready_i) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
        decode(insn_o, dc, da);
        n_vec++; if ({dc, da} !== e || err_o !== 1'b0) begin
          n_bad++; $display("FAIL roundtrip_%0d: got class %0d alu %0d err %b expected class %0d alu %0d err 0",
                            got, dc, da, err_o, e[7:4], e[3:0]); end
        got++;
      end
    end
    @(negedge clk);
    valid_i = 1'b0;
    n_vec++; if (got !== N) begin n_bad++; $display("FAIL roundtrip_count: got %0d expected %0d", got, N); end
  endtask

  initial begin
    test_reset();
    test_imm_add();
    test_rtype_sub();
    test_branch_odd();
    test_boundaries();
    test_back_to_back();
    test_reset_midflight();
    test_random_roundtrip();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/insn_encoder.md
INSN_ENCODER -- requirements
Module: insn_encoder

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, meaning instruction and immediate width.
REQ-002 SHALL have ports, one per line (name  direction  width  meaning):
- clk  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- valid_i  in  1  request valid
- ready_o  out  1  encoder can accept a request
- class_i  in  4  instruction class (shared-package enum: R_TYPE, IMM, LOADS, STORES, BRANCHES, JAL, JALR, LUI, AUIPC)
- alusel_i  in  4  ALU op (shared ALU constants ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PCADD)
- funct3_i  in  3  funct3 for LOADS, STORES and BRANCHES
- rd_i, rs1_i, rs2_i  in  5 each  register indices
- imm_i  in  DWIDTH  immediate value, signed byte offset or full upper value
- valid_o  out  1  encoded word valid
- ready_i  in  1  consumer accepts the word
- insn_o  out  DWIDTH  encoded RV32I instruction
- err_o  out  1  request was illegal; insn_o is NOP
- enc_cnt_o  out  16  accepted-legal counter
- err_cnt_o  out  16  accepted-illegal counter

Function
REQ-003 SHALL be the inverse of the control decoder: a legal request SHALL yield a word that the decoder maps back to the same class and alusel.
REQ-004 SHALL transfer a request when valid_i && ready_o, and an output when valid_o && ready_i.
REQ-005 SHALL be a 2-stage pipeline: S1 registers the request and performs range/legality checks; S2 registers the packed word. Latency is 2 cycles from input transfer to valid_o with no stall.
REQ-006 SHALL drive ready_o = !s1_valid || !s2_valid || ready_i, with no combinational path from valid_i to ready_o.
REQ-007 SHALL hold insn_o, err_o and valid_o stable while valid_o && !ready_i.
REQ-008 SHALL sustain 1 word per cycle when ready_i stays high, and SHALL neither drop nor duplicate requests under any ready_i pattern.
REQ-009 SHALL set R_TYPE funct7 to 0100000 for SUB/SRA and 0000000 otherwise. PCADD is illegal for R_TYPE.
REQ-010 SHALL encode IMM with alusel in {ADD, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU}. Non-shifts need imm in [-2048, 2047]. Shifts need imm in [0, 31], with insn[30]=1 only for SRA.
REQ-011 SHALL require imm in [-2048, 2047] for LOADS, STORES and JALR.
REQ-012 SHALL require LOADS funct3 in {000, 001, 010, 100, 101} and STORES funct3 in {000, 001, 010}.
REQ-013 SHALL require BRANCHES funct3 in {000, 001, 100, 101, 110, 111} and imm even in [-4096, 4094].
REQ-014 SHALL require JAL imm even in [-1048576, 1048574].
REQ-015 SHALL require imm[11:0]==0 for LUI/AUIPC and place imm[31:12] in insn[31:12].
REQ-016 SHALL treat any violation, or an unknown class_i, as illegal: insn_o=32'h00000013, err_o=1.
REQ-017 SHALL increment enc_cnt_o or err_cnt_o when the S2 output transfers; both counters saturate at 16'hFFFF.

Reset
REQ-018 SHALL, while reset_n=0 (asynchronous), clear s1_valid, s2_valid and valid_o.
REQ-019 SHALL, while reset_n=0, clear insn_o, err_o, enc_cnt_o and err_cnt_o.
REQ-020 SHALL drive ready_o=1 during and after reset.
REQ-021 SHALL discard any in-flight request on reset assertion mid-operation.

Structure
REQ-022 SHALL take the class enum, ALU constants and opcode constants from the shared package/constants header. The module SHALL NOT redefine them.
REQ-023 SHALL put the S1 legality/range check in one combinational sub-module, insn_field_check, with inputs class, alusel, funct3 and imm, and output illegal.

Verification
REQ-024 Bench SHALL cover: IMM, ADD, rd=1, rs1=0, imm=5 -> after 2 cycles insn_o=32'h00500093, err_o=0.
REQ-025 Bench SHALL cover: R_TYPE, SUB, rd=3, rs1=1, rs2=2 -> insn_o=32'h402081B3.
REQ-026 Bench SHALL cover: BRANCHES, funct3=000, imm=3 (odd) -> insn_o=32'h00000013, err_o=1, err_cnt_o=1.
REQ-027 Bench SHALL cover: 4 back-to-back requests with ready_i low for 3 cycles -> ready_o=0 once both stages are full, insn_o held stable, all 4 words emitted in order, enc_cnt_o=4.
REQ-028 Bench SHALL cover: reset_n asserted with both stages full -> valid_o=0 immediately, counters=0, ready_o=1.
REQ-029 Bench SHALL cover: random legal requests fed through the control decoder -> class and alusel round-trip match on 10k words.
